// File: rtl/ahb_master_burst_if.sv
// AHB-Lite bus bundle between the burst initiator (master modport) and a slave.
interface ahb_master_burst_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic [1:0]    hresp;

    modport master (
        output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_master_burst.sv
// AHB-Lite initiator: turns one-shot word-burst commands into pipelined NONSEQ/SEQ
// transfers with wait-state handling and two-cycle ERROR abort.
module ahb_master_burst #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int LENW = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic [DW-1:0]     wdata,
    output logic              wdata_ready,
    output logic [DW-1:0]     rdata,
    output logic              rdata_valid,
    output logic              done,
    output logic              err,
    ahb_master_burst_if.master bus
);

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [1:0] HR_ERROR  = 2'd1;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_ERR
    } state_t;

    state_t          state;
    logic [LENW-1:0] beats_left;
    logic            dp_active;
    logic            dp_write;
    logic            data_err;
    logic            accept;
    logic [AW-1:0]   next_addr;
    logic [2:0]      burst_code;

    assign bus.hsize = 3'b010;
    assign bus.hprot = 4'b0011;

    // An ERROR response on the live data phase blocks acceptance of the pending address.
    assign data_err    = dp_active && (bus.hresp == HR_ERROR);
    assign accept      = (state == S_ADDR) && bus.hready && !data_err;
    assign wdata_ready = accept && bus.hwrite;
    assign next_addr   = bus.haddr + AW'(4);

    always_comb begin
        burst_code = HB_INCR;
        if (cmd_len == LENW'(0))       burst_code = HB_SINGLE;
        else if (cmd_len == LENW'(3))  burst_code = HB_INCR4;
        else if (cmd_len == LENW'(7))  burst_code = HB_INCR8;
        else if (cmd_len == LENW'(15)) burst_code = HB_INCR16;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cmd_ready   <= 1'b1;
            bus.haddr   <= '0;
            bus.htrans  <= HT_IDLE;
            bus.hwrite  <= 1'b0;
            bus.hburst  <= HB_SINGLE;
            bus.hwdata  <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            beats_left  <= '0;
            dp_active   <= 1'b0;
            dp_write    <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;

            if (bus.hready && dp_active && !dp_write && !data_err) begin
                rdata       <= bus.hrdata;
                rdata_valid <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        bus.haddr  <= cmd_addr & ~AW'(3);
                        bus.htrans <= HT_NONSEQ;
                        bus.hwrite <= cmd_write;
                        bus.hburst <= burst_code;
                        beats_left <= cmd_len;
                        cmd_ready  <= 1'b0;
                        state      <= S_ADDR;
                    end
                end

                S_ADDR, S_LAST: begin
                    if (data_err) begin
                        dp_active  <= 1'b0;
                        bus.htrans <= HT_IDLE;
                        if (bus.hready) begin
                            done      <= 1'b1;
                            err       <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (bus.hready) begin
                        dp_active <= (state == S_ADDR);
                        dp_write  <= bus.hwrite;
                        if (state == S_ADDR) begin
                            if (bus.hwrite) bus.hwdata <= wdata;
                            if (beats_left == '0) begin
                                bus.htrans <= HT_IDLE;
                                state      <= S_LAST;
                            end else begin
                                bus.haddr  <= next_addr;
                                beats_left <= beats_left - LENW'(1);
                                // Crossing a 1KB page restarts the burst as undefined-length INCR.
                                if (next_addr[9:0] == 10'd0) begin
                                    bus.htrans <= HT_NONSEQ;
                                    bus.hburst <= HB_INCR;
                                end else begin
                                    bus.htrans <= HT_SEQ;
                                end
                            end
                        end else begin
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end

                S_ERR: begin
                    if (bus.hready) begin
                        done      <= 1'b1;
                        err       <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_master_burst.sv
// Randomized bench for ahb_master_burst: a reactive AHB slave plus a beat-list reference model.
module tb_ahb_master_burst;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wdata;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        err;

    ahb_master_burst_if bus ();

    ahb_master_burst dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected beat list of the command in flight, built from the burst rules.
    logic [31:0] m_addr  [16];
    logic [1:0]  m_trans [16];
    logic [2:0]  m_burst [16];
    logic [31:0] m_wd    [16];
    int          waits   [16];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slaveData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic logic [2:0] baseBurst(input int len);
        case (len)
            0:       return 3'd0;
            3:       return 3'd3;
            7:       return 3'd5;
            15:      return 3'd7;
            default: return 3'd1;
        endcase
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "/htrans"},      32'(bus.htrans), 32'd0);
        checkOutput({tag, "/haddr"},       bus.haddr, 32'd0);
        checkOutput({tag, "/hwrite"},      32'(bus.hwrite), 32'd0);
        checkOutput({tag, "/hburst"},      32'(bus.hburst), 32'd0);
        checkOutput({tag, "/hwdata"},      bus.hwdata, 32'd0);
        checkOutput({tag, "/cmd_ready"},   32'(cmd_ready), 32'd1);
        checkOutput({tag, "/wdata_ready"}, 32'(wdata_ready), 32'd0);
        checkOutput({tag, "/rdata_valid"}, 32'(rdata_valid), 32'd0);
        checkOutput({tag, "/done"},        32'(done), 32'd0);
        checkOutput({tag, "/err"},         32'(err), 32'd0);
    endtask

    // wait_mode: 0 zero-wait, 1 one wait per beat, 2 random 0..2. err_beat<0 means no error.
    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                                 input int len, input int wait_mode, input int err_beat);
        int          exp_done, exp_acc, exp_rv, t, acc, rv, wr_cnt, dp_beat, dp_wait;
        bit          dp_valid, dp_write, err_stage, done_seen, accepted, has_err;
        logic [31:0] a, dp_addr;
        bit          crossed;

        crossed = 0;
        for (int i = 0; i <= len; i++) begin
            a = (addr & ~32'd3) + 32'(4 * i);
            if (i > 0 && a[9:0] == 10'd0) crossed = 1;
            m_addr[i]  = a;
            m_trans[i] = (i == 0 || a[9:0] == 10'd0) ? 2'd2 : 2'd3;
            m_burst[i] = crossed ? 3'd1 : baseBurst(len);
            m_wd[i]    = $urandom;
        end
        for (int i = 0; i < 16; i++)
            waits[i] = (wait_mode == 0) ? 0 : (wait_mode == 1) ? 1 : int'($urandom_range(0, 2));

        has_err  = (err_beat >= 0 && err_beat <= len);
        t        = 0;
        exp_done = -1;
        for (int i = 0; i <= len; i++) begin
            if (i == err_beat) begin
                exp_done = t + 3;
                break;
            end
            if (i == len) exp_done = t + 2 + waits[i];
            else          t = t + 1 + waits[i];
        end
        exp_acc = has_err ? err_beat + 1 : len + 1;
        exp_rv  = wr ? 0 : (has_err ? err_beat : len + 1);

        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_addr    = addr;
        cmd_len     = 4'(len);
        wdata       = m_wd[0];
        bus.hready  = 1'b1;
        bus.hresp   = 2'd0;
        bus.hrdata  = $urandom;
        #1;
        checkOutput({name, "/cmd_ready_idle"}, 32'(cmd_ready), 32'd1);

        acc = 0; rv = 0; wr_cnt = 0;
        dp_valid = 0; dp_write = 0; err_stage = 0; done_seen = 0;
        dp_beat = 0; dp_wait = 0; dp_addr = '0;

        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            // Competing command while busy must be ignored.
            cmd_valid = (cyc < 2);
            cmd_addr  = $urandom;
            cmd_write = 1'($urandom);
            cmd_len   = 4'($urandom);
            wdata     = (acc <= len) ? m_wd[acc] : $urandom;
            if (dp_valid) begin
                if (dp_beat == err_beat) begin
                    bus.hready = err_stage;
                    bus.hresp  = 2'd1;
                end else begin
                    bus.hready = (dp_wait == 0);
                    bus.hresp  = 2'd0;
                end
                bus.hrdata = dp_write ? $urandom : slaveData(dp_addr);
            end else begin
                bus.hready = 1'b1;
                bus.hresp  = 2'd0;
                bus.hrdata = $urandom;
            end
            #1;

            if (cyc == 0) begin
                checkOutput({name, "/cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
                checkOutput({name, "/hsize"}, 32'(bus.hsize), 32'd2);
                checkOutput({name, "/hprot"}, 32'(bus.hprot), 32'd3);
            end
            if (dp_valid && dp_write)
                checkOutput({name, "/hwdata"}, bus.hwdata, m_wd[dp_beat]);
            if (dp_valid && dp_beat == err_beat && err_stage)
                checkOutput({name, "/htrans_after_err"}, 32'(bus.htrans), 32'd0);

            accepted = 0;
            if (bus.htrans[1]) begin
                if (acc > len) begin
                    checkOutput({name, "/extra_beat"}, 32'(acc), 32'(len));
                end else begin
                    checkOutput({name, "/haddr"},  bus.haddr, m_addr[acc]);
                    checkOutput({name, "/htrans"}, 32'(bus.htrans), 32'(m_trans[acc]));
                    checkOutput({name, "/hburst"}, 32'(bus.hburst), 32'(m_burst[acc]));
                    checkOutput({name, "/hwrite"}, 32'(bus.hwrite), 32'(wr));
                end
                if (bus.hready) begin
                    accepted = 1;
                    if (wr) checkOutput({name, "/wdata_ready"}, 32'(wdata_ready), 32'd1);
                end
            end
            if (wdata_ready) wr_cnt++;
            if (rdata_valid) begin
                if (rv < exp_rv) checkOutput({name, "/rdata"}, rdata, slaveData(m_addr[rv]));
                rv++;
            end
            if (done) begin
                done_seen = 1;
                checkOutput({name, "/done_cycle"}, 32'(cyc), 32'(exp_done));
                checkOutput({name, "/err"}, 32'(err), 32'(has_err));
                break;
            end

            if (dp_valid) begin
                if (bus.hready)              dp_valid = 0;
                else if (dp_beat == err_beat) err_stage = 1;
                else                          dp_wait--;
            end
            if (accepted) begin
                dp_valid  = 1;
                dp_beat   = acc;
                dp_addr   = bus.haddr;
                dp_write  = wr;
                dp_wait   = (acc <= 15) ? waits[acc] : 0;
                err_stage = 0;
                acc++;
            end
        end

        if (!done_seen) checkOutput({name, "/done_timeout"}, 32'd0, 32'd1);
        checkOutput({name, "/beats_accepted"}, 32'(acc), 32'(exp_acc));
        checkOutput({name, "/wdata_ready_count"}, 32'(wr_cnt), wr ? 32'(exp_acc) : 32'd0);
        checkOutput({name, "/rdata_valid_count"}, 32'(rv), 32'(exp_rv));

        @(negedge clk);
        cmd_valid  = 1'b0;
        bus.hready = 1'b1;
        bus.hresp  = 2'd0;
        #1;
        checkOutput({name, "/cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        checkOutput({name, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic resetMidBurst();
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_addr   = 32'h0000_2000;
        cmd_len    = 4'd15;
        wdata      = $urandom;
        bus.hready = 1'b1;
        bus.hresp  = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            wdata     = $urandom;
        end
        #1;
        checkOutput("rst_mid/active_before", 32'(bus.htrans[1]), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkResetState("rst_mid");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] addr;
        int          len, eb;

        rstn       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        wdata      = '0;
        bus.hready = 1'b1;
        bus.hresp  = 2'd0;
        bus.hrdata = '0;
        repeat (3) @(negedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        rstn = 1'b1;

        applyStimulus("single_wr",   1'b1, 32'h0000_0100, 0, 0, -1);
        applyStimulus("incr4_rd_ws", 1'b0, 32'h0000_0200, 3, 1, -1);
        applyStimulus("incr5_wr",    1'b1, 32'h0000_0500, 4, 0, -1);
        applyStimulus("cross_1k_rd", 1'b0, 32'h0000_03F8, 3, 0, -1);
        applyStimulus("err_incr8",   1'b1, 32'h0000_1000, 7, 0, 1);
        resetMidBurst();
        applyStimulus("after_reset", 1'b0, 32'h0000_0043, 15, 2, -1);

        for (int n = 0; n < 24; n++) begin
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                addr = (32'($urandom_range(1, 1000)) << 10) - 32'(4 * $urandom_range(0, 15))
                       + 32'($urandom_range(0, 3));
            else
                addr = $urandom & 32'h0FFF_FFFF;
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
            applyStimulus($sformatf("rand%0d", n), 1'($urandom), addr, len,
                          int'($urandom_range(0, 2)), eb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
